// File: rtl/decode_stage_if.sv
// Fetch/regfile/EX-side signal bundle for the decode stage.
// The slave view belongs to decode_stage; the master view is its environment.
interface decode_stage_if #(
  parameter int DSIZE = 16,
  parameter int RSIZE = 4
);
  logic             if_valid;
  logic [DSIZE-1:0] if_instr;
  logic [DSIZE-1:0] if_pc;
  logic             id_ready;
  logic             flush;
  logic [RSIZE-1:0] rf_raddr1, rf_raddr2;
  logic [DSIZE-1:0] rf_rdata1, rf_rdata2;
  logic             ex_ready;
  logic             ex_valid;
  logic [3:0]       ex_op;
  logic [RSIZE-1:0] ex_rd, ex_rs1, ex_rs2;
  logic [DSIZE-1:0] ex_a, ex_b, ex_imm, ex_pc;
  logic             ex_wen, ex_mem_rd, ex_mem_wr;
  logic             halted;
  logic [15:0]      stall_cnt;

  modport master (
    output if_valid, if_instr, if_pc, flush, rf_rdata1, rf_rdata2, ex_ready,
    input  id_ready, rf_raddr1, rf_raddr2, ex_valid, ex_op, ex_rd, ex_rs1, ex_rs2,
           ex_a, ex_b, ex_imm, ex_pc, ex_wen, ex_mem_rd, ex_mem_wr, halted, stall_cnt
  );
  modport slave (
    input  if_valid, if_instr, if_pc, flush, rf_rdata1, rf_rdata2, ex_ready,
    output id_ready, rf_raddr1, rf_raddr2, ex_valid, ex_op, ex_rd, ex_rs1, ex_rs2,
           ex_a, ex_b, ex_imm, ex_pc, ex_wen, ex_mem_rd, ex_mem_wr, halted, stall_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode: register-file addressing, ID/EX pipeline register,
// load-use interlock, branch flush and HLT latch.
module decode_stage #(
  parameter int DSIZE = 16,
  parameter int RSIZE = 4
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);
  typedef enum logic {RUN, HALT} state_e;

  typedef struct packed {
    logic [3:0]       op;
    logic [RSIZE-1:0] rd, rs1, rs2;
    logic [DSIZE-1:0] a, b, imm, pc;
    logic             wen, mem_rd, mem_wr;
  } idex_t;

  state_e           state_q, state_d;
  logic             ex_valid_q, ex_valid_d;
  idex_t            ex_q, ex_d, dec;
  logic [15:0]      stall_q, stall_d;
  logic [DSIZE-1:0] ins;
  logic [3:0]       op;
  logic             use1, use2, hazard, id_ready, xfer;

  assign ins = bus.if_instr;
  assign op  = ins[15:12];

  // a/b stay zero here; operands are attached in the next-state block so the
  // regfile read path does not loop back through this process.
  always_comb begin
    dec     = '0;
    use1    = 1'b0;
    use2    = 1'b0;
    dec.op  = op;
    dec.rd  = ins[11:8];
    dec.pc  = bus.if_pc;
    case (op)
      4'h8: begin use1 = 1'b1; dec.wen = 1'b1; dec.mem_rd = 1'b1;
                  dec.imm = {{(DSIZE-4){ins[3]}}, ins[3:0]}; end
      4'h9: begin use1 = 1'b1; use2 = 1'b1; dec.mem_wr = 1'b1;
                  dec.imm = {{(DSIZE-4){ins[3]}}, ins[3:0]}; end
      4'hA: begin use2 = 1'b1; dec.wen = 1'b1; dec.imm = {{(DSIZE-8){1'b0}}, ins[7:0]}; end
      4'hB: begin dec.wen = 1'b1; dec.imm = {{(DSIZE-8){ins[7]}}, ins[7:0]}; end
      4'hC: begin dec.rd = {1'b0, ins[11:9]}; dec.imm = {{(DSIZE-9){ins[8]}}, ins[8:0]}; end
      4'hD: begin dec.rd = RSIZE'(15); dec.wen = 1'b1;
                  dec.imm = {{(DSIZE-12){ins[11]}}, ins[11:0]}; end
      4'hE: use1 = 1'b1;
      4'hF: ;
      default: begin use1 = 1'b1; use2 = 1'b1; dec.wen = 1'b1; end
    endcase
    dec.rs1 = use1 ? ins[7:4] : '0;
    dec.rs2 = use2 ? (op[3] ? ins[11:8] : ins[3:0]) : '0;
    if (dec.rd == '0) dec.wen = 1'b0;
  end

  // Unused ports read address 0, so they never match a nonzero load target.
  assign hazard = ex_valid_q && ex_q.mem_rd && (ex_q.rd != '0) &&
                  ((ex_q.rd == dec.rs1) || (ex_q.rd == dec.rs2));
  assign id_ready = (state_q == RUN) &&
                    (bus.flush || (!hazard && (!ex_valid_q || bus.ex_ready)));
  assign xfer = bus.if_valid && id_ready && !bus.flush;

  always_comb begin
    state_d    = state_q;
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    stall_d    = stall_q;
    if (bus.flush) begin
      ex_valid_d = 1'b0;
    end else if (!ex_valid_q || bus.ex_ready) begin
      ex_valid_d = 1'b0;
      if (hazard) begin
        if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
      end else if (xfer) begin
        ex_valid_d = 1'b1;
        ex_d       = dec;
        ex_d.a     = bus.rf_rdata1;
        ex_d.b     = bus.rf_rdata2;
        if (op == 4'hF) state_d = HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.id_ready  = id_ready;
  assign bus.rf_raddr1 = dec.rs1;
  assign bus.rf_raddr2 = dec.rs2;
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_op     = ex_q.op;
  assign bus.ex_rd     = ex_q.rd;
  assign bus.ex_rs1    = ex_q.rs1;
  assign bus.ex_rs2    = ex_q.rs2;
  assign bus.ex_a      = ex_q.a;
  assign bus.ex_b      = ex_q.b;
  assign bus.ex_imm    = ex_q.imm;
  assign bus.ex_pc     = ex_q.pc;
  assign bus.ex_wen    = ex_q.wen;
  assign bus.ex_mem_rd = ex_q.mem_rd;
  assign bus.ex_mem_wr = ex_q.mem_wr;
  assign bus.halted    = (state_q == HALT);
  assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_decode_stage.sv
// Decode-stage bench: decode vector table, directed hazard/stall/flush/HLT
// sequences, then random traffic against a cycle-level reference model.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if bus ();
  decode_stage dut (.clk(clk), .rst(rst), .bus(bus));

  logic [15:0] regs [16];
  assign bus.rf_rdata1 = regs[bus.rf_raddr1];
  assign bus.rf_rdata2 = regs[bus.rf_raddr2];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  op, rd, rs1, rs2;
    logic [15:0] imm;
    logic        wen, mrd, mwr;
  } dec_t;

  typedef struct {
    logic [15:0] ins;
    logic [3:0]  r1, r2, rd;
    logic        chkrd, wen, mrd, mwr;
    logic [15:0] imm;
  } vec_t;

  // reference model state
  dec_t        m_d;
  logic [15:0] m_a, m_b, m_pc;
  bit          m_v, m_h;
  int          m_st;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sx(input int v, input int n);
    return 16'(v >= (1 << (n - 1)) ? v - (1 << n) : v);
  endfunction

  function automatic dec_t dec(input logic [15:0] ins);
    dec_t d;
    int op, f1, f2, f3;
    op = int'(ins[15:12]); f1 = int'(ins[11:8]); f2 = int'(ins[7:4]); f3 = int'(ins[3:0]);
    d.op = ins[15:12]; d.rd = ins[11:8]; d.rs1 = 0; d.rs2 = 0; d.imm = 0;
    d.wen = 0; d.mrd = 0; d.mwr = 0;
    if (op < 8) begin d.rs1 = 4'(f2); d.rs2 = 4'(f3); d.wen = 1; end
    else case (op)
      8:  begin d.rs1 = 4'(f2); d.wen = 1; d.mrd = 1; d.imm = sx(f3, 4); end
      9:  begin d.rs1 = 4'(f2); d.rs2 = 4'(f1); d.mwr = 1; d.imm = sx(f3, 4); end
      10: begin d.rs2 = 4'(f1); d.wen = 1; d.imm = 16'(int'(ins[7:0])); end
      11: begin d.wen = 1; d.imm = sx(int'(ins[7:0]), 8); end
      12: begin d.rd = 4'(f1 / 2); d.imm = sx(int'(ins[8:0]), 9); end
      13: begin d.rd = 4'd15; d.wen = 1; d.imm = sx(int'(ins[11:0]), 12); end
      14: d.rs1 = 4'(f2);
      default: ;
    endcase
    if (d.rd == 0) d.wen = 0;
    return d;
  endfunction

  function automatic bit haz(input dec_t n);
    return m_v && m_d.mrd && (m_d.rd != 0) && (n.rs1 == m_d.rd || n.rs2 == m_d.rd);
  endfunction

  function automatic bit exp_ready(input dec_t n);
    return !m_h && (bus.flush || (!haz(n) && (!m_v || bus.ex_ready)));
  endfunction

  task automatic set_in(input bit v, input logic [15:0] ins, input logic [15:0] pc,
                        input bit er, input bit fl);
    bus.if_valid = v; bus.if_instr = ins; bus.if_pc = pc;
    bus.ex_ready = er; bus.flush = fl;
  endtask

  task automatic pre();
    dec_t n;
    #2;
    n = dec(bus.if_instr);
    chk("id_ready", bus.id_ready, exp_ready(n));
    chk("rf_raddr1", bus.rf_raddr1, n.rs1);
    chk("rf_raddr2", bus.rf_raddr2, n.rs2);
  endtask

  task automatic post();
    dec_t n, nd;
    bit hz, rdy, nv, nh;
    int nst;
    logic [15:0] na, nb, npc;
    n = dec(bus.if_instr); hz = haz(n); rdy = exp_ready(n);
    nv = m_v; nh = m_h; nst = m_st; nd = m_d; na = m_a; nb = m_b; npc = m_pc;
    if (bus.flush) nv = 0;
    else if (!m_v || bus.ex_ready) begin
      nv = 0;
      if (hz) nst = (m_st < 65535) ? m_st + 1 : m_st;
      else if (bus.if_valid && rdy) begin
        nv = 1; nd = n; na = regs[n.rs1]; nb = regs[n.rs2]; npc = bus.if_pc;
        if (n.op == 4'hF) nh = 1;
      end
    end
    @(posedge clk); #1;
    m_v = nv; m_h = nh; m_st = nst; m_d = nd; m_a = na; m_b = nb; m_pc = npc;
    chk("ex_valid", bus.ex_valid, m_v);
    chk("halted", bus.halted, m_h);
    chk("stall_cnt", bus.stall_cnt, 16'(m_st));
    if (m_v) begin
      chk("ex_op", bus.ex_op, m_d.op);
      if (!(m_d.op inside {4'h9, 4'hE, 4'hF})) chk("ex_rd", bus.ex_rd, m_d.rd);
      chk("ex_rs1", bus.ex_rs1, m_d.rs1);
      chk("ex_rs2", bus.ex_rs2, m_d.rs2);
      chk("ex_a", bus.ex_a, m_a);
      chk("ex_b", bus.ex_b, m_b);
      chk("ex_imm", bus.ex_imm, m_d.imm);
      chk("ex_pc", bus.ex_pc, m_pc);
      chk("ex_wen", bus.ex_wen, m_d.wen);
      chk("ex_mem_rd", bus.ex_mem_rd, m_d.mrd);
      chk("ex_mem_wr", bus.ex_mem_wr, m_d.mwr);
    end
  endtask

  // Asynchronous pulse: outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b0; #1;
    chk("rst ex_valid", bus.ex_valid, 0);
    chk("rst halted", bus.halted, 0);
    chk("rst stall_cnt", bus.stall_cnt, 0);
    chk("rst ex_a", bus.ex_a, 0);
    chk("rst ex_op", bus.ex_op, 0);
    chk("rst ex_pc", bus.ex_pc, 0);
    chk("rst ex_wen", bus.ex_wen, 0);
    rst = 1'b1; #1;
    m_v = 0; m_h = 0; m_st = 0; m_a = 0; m_b = 0; m_pc = 0;
    m_d = dec(16'hF000);
  endtask

  vec_t tab [12];

  initial begin
    logic [15:0] ins;
    tab[0]  = '{16'h0312, 4'd1, 4'd2, 4'd3,  1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    tab[1]  = '{16'h7A5C, 4'd5, 4'hC, 4'hA,  1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    tab[2]  = '{16'h8419, 4'd1, 4'd0, 4'd4,  1'b1, 1'b1, 1'b1, 1'b0, 16'hFFF9};
    tab[3]  = '{16'h9617, 4'd1, 4'd6, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 16'h0007};
    tab[4]  = '{16'hA3F0, 4'd0, 4'd3, 4'd3,  1'b1, 1'b1, 1'b0, 1'b0, 16'h00F0};
    tab[5]  = '{16'hB280, 4'd0, 4'd0, 4'd2,  1'b1, 1'b1, 1'b0, 1'b0, 16'hFF80};
    tab[6]  = '{16'hC7FF, 4'd0, 4'd0, 4'd3,  1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF};
    tab[7]  = '{16'hC100, 4'd0, 4'd0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 16'hFF00};
    tab[8]  = '{16'hD800, 4'd0, 4'd0, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 16'hF800};
    tab[9]  = '{16'hE050, 4'd5, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tab[10] = '{16'h0012, 4'd1, 4'd2, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tab[11] = '{16'hB0FF, 4'd0, 4'd0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF};

    for (int i = 0; i < 16; i++) regs[i] = (i == 0) ? 16'h0 : 16'(16'h1000 + i * 16'h0111);
    set_in(0, 16'h0, 16'h0, 1, 0);
    @(posedge clk); #1;
    do_reset();

    // decode table, one instruction per cycle
    for (int i = 0; i < 12; i++) begin
      set_in(1, tab[i].ins, 16'(16'h0100 + i), 1, 0);
      pre();
      chk("tab raddr1", bus.rf_raddr1, tab[i].r1);
      chk("tab raddr2", bus.rf_raddr2, tab[i].r2);
      post();
      chk("tab valid", bus.ex_valid, 1);
      if (tab[i].chkrd) chk("tab rd", bus.ex_rd, tab[i].rd);
      chk("tab rs1", bus.ex_rs1, tab[i].r1);
      chk("tab rs2", bus.ex_rs2, tab[i].r2);
      chk("tab wen", bus.ex_wen, tab[i].wen);
      chk("tab mem_rd", bus.ex_mem_rd, tab[i].mrd);
      chk("tab mem_wr", bus.ex_mem_wr, tab[i].mwr);
      chk("tab imm", bus.ex_imm, tab[i].imm);
      chk("tab a", bus.ex_a, regs[tab[i].r1]);
    end

    // ADD r3,r1,r2
    do_reset();
    regs[1] = 16'd5; regs[2] = 16'd7; regs[3] = 16'd11;
    set_in(1, 16'h0312, 16'h0010, 1, 0);
    pre(); chk("add raddr1", bus.rf_raddr1, 1); chk("add raddr2", bus.rf_raddr2, 2);
    post();
    chk("add valid", bus.ex_valid, 1); chk("add a", bus.ex_a, 5); chk("add b", bus.ex_b, 7);
    chk("add rd", bus.ex_rd, 3); chk("add wen", bus.ex_wen, 1);

    // LW r4 then ADD r5,r4,r4: one bubble
    set_in(1, 16'h8412, 16'h0011, 1, 0); pre(); post();
    set_in(1, 16'h0544, 16'h0012, 1, 0);
    pre(); chk("lu id_ready", bus.id_ready, 0);
    post(); chk("lu bubble", bus.ex_valid, 0); chk("lu stall", bus.stall_cnt, 1);
    pre(); chk("lu id_ready2", bus.id_ready, 1);
    post(); chk("lu valid", bus.ex_valid, 1); chk("lu rs1", bus.ex_rs1, 4);
    chk("lu rs2", bus.ex_rs2, 4); chk("lu stall2", bus.stall_cnt, 1);

    // EX stall for 3 cycles holds ID/EX and fetch
    set_in(1, 16'h0312, 16'h0020, 1, 0); pre(); post();
    regs[1] = 16'd9;
    set_in(1, 16'h0123, 16'h0021, 0, 0);
    for (int k = 0; k < 3; k++) begin
      pre(); chk("exst id_ready", bus.id_ready, 0);
      post(); chk("exst valid", bus.ex_valid, 1); chk("exst a", bus.ex_a, 5);
      chk("exst rd", bus.ex_rd, 3); chk("exst pc", bus.ex_pc, 16'h0020);
    end
    bus.ex_ready = 1;
    pre(); chk("exst release", bus.id_ready, 1);
    post(); chk("exst rd2", bus.ex_rd, 1); chk("exst a2", bus.ex_a, 7); chk("exst b2", bus.ex_b, 11);

    // flush beats EX stall; HLT accepted under flush is discarded
    set_in(1, 16'hF000, 16'h0030, 0, 1);
    pre(); chk("fl id_ready", bus.id_ready, 1);
    post(); chk("fl valid", bus.ex_valid, 0); chk("fl halted", bus.halted, 0);
    set_in(1, 16'h0312, 16'h0031, 1, 0);
    pre(); chk("fl after", bus.id_ready, 1); post();

    // HLT retires, blocks fetch, reset recovers
    set_in(1, 16'hF000, 16'h0040, 1, 0); pre(); post();
    chk("hlt halted", bus.halted, 1); chk("hlt valid", bus.ex_valid, 1);
    set_in(1, 16'h0312, 16'h0041, 0, 0);
    pre(); chk("hlt id_ready", bus.id_ready, 0);
    post(); chk("hlt still", bus.halted, 1);
    do_reset();
    set_in(1, 16'h0312, 16'h0042, 1, 0);
    pre(); chk("hlt rst ready", bus.id_ready, 1); post();

    // r0 destinations never write, and a load to r0 never interlocks
    set_in(1, 16'h0012, 16'h0050, 1, 0); pre(); post(); chk("r0 add wen", bus.ex_wen, 0);
    set_in(1, 16'hB0FF, 16'h0051, 1, 0); pre(); post(); chk("r0 llb wen", bus.ex_wen, 0);
    set_in(1, 16'h8010, 16'h0052, 1, 0); pre(); post();
    set_in(1, 16'h0500, 16'h0053, 1, 0);
    pre(); chk("r0 lw ready", bus.id_ready, 1);
    post(); chk("r0 lw valid", bus.ex_valid, 1); chk("r0 lw stall", bus.stall_cnt, 0);

    // random traffic vs model; small register set raises hazard density
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] op;
      if (m_h && $urandom_range(0, 3) == 0) do_reset();
      if ($urandom_range(0, 7) == 0) regs[$urandom_range(1, 15)] = 16'($urandom);
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 9) != 0) op = 4'h8;
      ins = {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) ins[11:0] = 12'($urandom);
      set_in($urandom_range(0, 3) != 0, ins, 16'($urandom),
             $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      pre();
      post();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
